tact_debounce: RTL
==================

TACT_DEBOUNCE -- requirements
Module: tact_debounce

Interface
REQ-001 Parameter W_DB, default 18, sets the debounce counter width; the qualification time is 2^W_DB cycles (about 10.9 ms at 24 MHz).
REQ-002 Parameter W_LONG, default 25, sets the long-press counter width; the long-press threshold is 2^W_LONG - 1 cycles in the pressed states.
REQ-003 Parameter TACT_ON, default 1'b0, is the raw button level that means pressed; TACT_OFF is its complement.
REQ-004 CLK_24MHz  in  1  sole clock; all logic on the rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 Tact1  in  1  raw, asynchronous, bouncing push-button input.
REQ-007 tact_level  out  1  debounced level; 1 = pressed.
REQ-008 press_pulse  out  1  one-cycle strobe on a qualified press.
REQ-009 release_pulse  out  1  one-cycle strobe on a qualified release.
REQ-010 long_pulse  out  1  one-cycle strobe when a press exceeds the long threshold.
REQ-011 press_cnt  out  8  count of qualified presses, wrapping.

Function
REQ-012 Tact1 SHALL pass through a 2-flop synchronizer; the internal signal raw_p = (sync output == TACT_ON).
REQ-013 The FSM SHALL have four states: ST_RELEASED, ST_PRESS_WAIT, ST_PRESSED and ST_RELEASE_WAIT.
REQ-014 ST_RELEASED: when raw_p = 1, go to ST_PRESS_WAIT and clear the debounce counter; otherwise hold.
REQ-015 ST_PRESS_WAIT: when raw_p = 0, return to ST_RELEASED and clear the counter; when the counter is all-ones and raw_p = 1, go to ST_PRESSED; otherwise increment.
REQ-016 Entry to ST_PRESSED from ST_PRESS_WAIT SHALL set tact_level = 1, assert press_pulse for exactly one cycle, increment press_cnt by 1 (mod 256), and clear the long counter.
REQ-017 ST_PRESSED: when raw_p = 0, go to ST_RELEASE_WAIT and clear the debounce counter; otherwise increment the long counter, saturating at all-ones.
REQ-018 long_pulse SHALL assert for one cycle only on the cycle the long counter reaches all-ones, and at most once per qualified press.
REQ-019 ST_RELEASE_WAIT: when raw_p = 1, return to ST_PRESSED with no pulse, no press_cnt change, and the long counter held; when the counter is all-ones and raw_p = 0, go to ST_RELEASED; otherwise increment.
REQ-020 Entry to ST_RELEASED from ST_RELEASE_WAIT SHALL set tact_level = 0 and assert release_pulse for one cycle.
REQ-021 tact_level SHALL stay constant through the wait states: bounces shorter than 2^W_DB cycles produce no output change.
REQ-022 Latency from a clean Tact1 edge to the pulse SHALL be exactly 2 + 2^W_DB + 1 cycles, fixed for both press and release.
REQ-023 press_pulse, release_pulse and long_pulse SHALL be registered outputs and mutually exclusive in any cycle.
REQ-024 long_pulse SHALL be suppressed while the FSM is in ST_RELEASE_WAIT.

Reset
REQ-025 RST = 1 SHALL force: synchronizer flops = TACT_OFF, state = ST_RELEASED, both counters = 0, tact_level = 0, all pulses = 0, press_cnt = 0.
REQ-026 RST SHALL take priority over every FSM transition, including in mid-wait or mid-long-count.
REQ-027 A button held through reset release SHALL be qualified as a new press with full latency.

Verification (W_DB = 3, W_LONG = 5)
REQ-028 Clean press: Tact1 low for 20 cycles -> press_pulse exactly 11 cycles after the falling edge, tact_level = 1, press_cnt = 1.
REQ-029 Bounce: Tact1 toggles low for 5 cycles and high for 2, repeated 4 times, then stays high -> no pulses, tact_level = 0, press_cnt = 0.
REQ-030 Long press: Tact1 held low for 60 cycles -> exactly one long_pulse, 31 cycles after press_pulse; release -> one release_pulse.
REQ-031 Release glitch: while pressed, Tact1 high for 4 cycles then low -> no release_pulse, no second press_pulse, press_cnt unchanged.
REQ-032 Wrap and reset: 256 qualified presses -> press_cnt = 0; RST asserted during ST_PRESS_WAIT -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/tact_debounce.sv
// Push-button debouncer: 2-flop synchronizer, four-state qualification FSM,
// press/release/long-press strobes and a wrapping press counter.
module tact_debounce #(
    parameter int unsigned W_DB    = 18,
    parameter int unsigned W_LONG  = 25,
    parameter logic        TACT_ON = 1'b0
) (
    input  logic       CLK_24MHz,
    input  logic       RST,
    input  logic       Tact1,
    output logic       tact_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_cnt
);

    localparam logic TACT_OFF = ~TACT_ON;

    localparam int unsigned W_CNT = 8;
    localparam int unsigned W_ST  = 2;

    localparam logic [W_DB-1:0]   DB_MAX   = '1;
    localparam logic [W_LONG-1:0] LONG_MAX = '1;

    localparam logic [W_ST-1:0] ST_RELEASED     = 2'd0;
    localparam logic [W_ST-1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [W_ST-1:0] ST_PRESSED      = 2'd2;
    localparam logic [W_ST-1:0] ST_RELEASE_WAIT = 2'd3;

    logic              sync1_q, sync2_q;
    logic              raw_p;

    logic [W_ST-1:0]   state_q,   state_d;
    logic [W_DB-1:0]   db_q,      db_d;
    logic [W_LONG-1:0] long_q,    long_d;
    logic              level_q,   level_d;
    logic              press_q,   press_d;
    logic              release_q, release_d;
    logic              lpulse_q,  lpulse_d;
    logic [W_CNT-1:0]  cnt_q,     cnt_d;

    // Metastability guard; flops idle at the released level.
    always_ff @(posedge CLK_24MHz) begin
        if (RST) begin
            sync1_q <= TACT_OFF;
            sync2_q <= TACT_OFF;
        end else begin
            sync1_q <= Tact1;
            sync2_q <= sync1_q;
        end
    end

    assign raw_p = (sync2_q == TACT_ON);

    // State, counters and registered outputs.
    always_ff @(posedge CLK_24MHz) begin
        if (RST) begin
            state_q   <= ST_RELEASED;
            db_q      <= '0;
            long_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            lpulse_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            db_q      <= db_d;
            long_q    <= long_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            lpulse_q  <= lpulse_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and next-output logic; strobes default low every cycle.
    always_comb begin
        state_d   = state_q;
        db_d      = db_q;
        long_d    = long_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        lpulse_d  = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            ST_RELEASED: begin
                if (raw_p) begin
                    state_d = ST_PRESS_WAIT;
                    db_d    = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!raw_p) begin
                    state_d = ST_RELEASED;
                    db_d    = '0;
                end else if (db_q == DB_MAX) begin
                    state_d = ST_PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = cnt_q + W_CNT'(1);
                    long_d  = '0;
                end else begin
                    db_d = db_q + W_DB'(1);
                end
            end
            ST_PRESSED: begin
                if (!raw_p) begin
                    state_d = ST_RELEASE_WAIT;
                    db_d    = '0;
                end else if (long_q != LONG_MAX) begin
                    // Saturation makes the strobe fire once per press.
                    long_d   = long_q + W_LONG'(1);
                    lpulse_d = (long_d == LONG_MAX);
                end
            end
            ST_RELEASE_WAIT: begin
                if (raw_p) begin
                    state_d = ST_PRESSED;
                end else if (db_q == DB_MAX) begin
                    state_d   = ST_RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_d = db_q + W_DB'(1);
                end
            end
            default: begin
                state_d = ST_RELEASED;
            end
        endcase
    end

    assign tact_level    = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = lpulse_q;
    assign press_cnt     = cnt_q;

endmodule
